sega_pad_reader: RTL and testbench

Scans a 3-button Sega gamepad over its six data pins and select line, and presents the decoded button state as the 32-bit `SegaData` word. The processor's memory stage returns this word for loads from the gamepad I/O address (low address byte `0xfd`). The block owns the pad side of that interface: it drives select, samples both select phases, and updates `SegaData` atomically once per full scan. `SegaData` is a stable register, so a load always sees a consistent snapshot.

---
 rtl/sega_pad_reader_pkg.sv | 48 ++++
 rtl/sega_pad_reader_if.sv | 24 ++
 rtl/sega_pad_reader_sync2.sv | 27 ++
 rtl/sega_pad_reader.sv | 75 +++++++
 tb/tb_sega_pad_reader.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sega_pad_reader_pkg.sv
// Shared constants for the Sega 3-button pad reader: SegaData bit layout,
// pad pin positions, select-phase encoding and the memory-mapped address.
package sega_pkg;

    localparam int SEGA_W       = 32;

    localparam int SEGA_UP      = 0;
    localparam int SEGA_DOWN    = 1;
    localparam int SEGA_LEFT    = 2;
    localparam int SEGA_RIGHT   = 3;
    localparam int SEGA_B       = 4;
    localparam int SEGA_C       = 5;
    localparam int SEGA_A       = 6;
    localparam int SEGA_START   = 7;
    localparam int SEGA_PRESENT = 8;

    // Bit positions inside PadPins_n = {pin9, pin6, pin4, pin3, pin2, pin1}
    localparam int SEGA_PIN1 = 0;
    localparam int SEGA_PIN2 = 1;
    localparam int SEGA_PIN3 = 2;
    localparam int SEGA_PIN4 = 3;
    localparam int SEGA_PIN6 = 4;
    localparam int SEGA_PIN9 = 5;

    typedef enum logic {
        SEL_LO = 1'b0,
        SEL_HI = 1'b1
    } sega_sel_e;

    localparam logic [7:0] SEGA_FDAddr = 8'hfd;

    // Assemble the button word; with no pad attached the whole word reads zero.
    function automatic logic [SEGA_W-1:0] sega_pack(input logic [5:0] hi,
                                                    input logic       a,
                                                    input logic       start,
                                                    input logic       present);
        logic [SEGA_W-1:0] w;
        w = '0;
        if (present) begin
            w[5:0]         = hi;
            w[SEGA_A]       = a;
            w[SEGA_START]   = start;
            w[SEGA_PRESENT] = 1'b1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sega_pad_reader_if.sv
// Pad-side pins plus the decoded word offered to the memory stage.
interface sega_pad_reader_if;
    import sega_pkg::*;

    logic [5:0]        PadPins_n;
    logic              SegaSelect;
    logic [SEGA_W-1:0] SegaData;
    logic              SegaUpdate;

    modport master (
        input  PadPins_n,
        output SegaSelect,
        output SegaData,
        output SegaUpdate
    );

    modport slave (
        output PadPins_n,
        input  SegaSelect,
        input  SegaData,
        input  SegaUpdate
    );

endinterface

// File: rtl/sega_pad_reader_sync2.sv
// Two-flop synchronizer with a configurable reset value.
module sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sega_pad_reader.sv
// Alternates the pad select line, samples both select phases and publishes
// the decoded button word once per full scan.
module sega_pad_reader
    import sega_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 1000
) (
    input  logic               clk,
    input  logic               rst,
    sega_pad_reader_if.master  pad
);

    localparam logic [15:0] CNT_LOAD = 16'(HALF_PERIOD - 1);

    logic [5:0]        pins_sync_n;
    logic [5:0]        pins_act;
    logic              present_d;
    logic [SEGA_W-1:0] data_d;

    sega_sel_e         state_q;
    logic [15:0]       cnt_q;
    logic              sel_q;
    logic              upd_q;
    logic [5:0]        hi_q;
    logic [SEGA_W-1:0] data_q;

    sync2 #(
        .WIDTH   (6),
        .RST_VAL (6'h3f)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pad.PadPins_n),
        .q_o (pins_sync_n)
    );

    assign pins_act = ~pins_sync_n;

    // During SEL_LO a real pad grounds pins 3 and 4; Up/Down copies are ignored.
    assign present_d = pins_act[SEGA_PIN3] & pins_act[SEGA_PIN4];
    assign data_d    = sega_pack(hi_q, pins_act[SEGA_PIN6], pins_act[SEGA_PIN9], present_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEL_HI;
            cnt_q   <= CNT_LOAD;
            sel_q   <= 1'b1;
            upd_q   <= 1'b0;
            hi_q    <= '0;
            data_q  <= '0;
        end else begin
            // Raised one cycle early so the registered pulse lands on the SEL_LO count-0 cycle.
            upd_q <= (state_q == SEL_LO) && (cnt_q == 16'd1);
            if (cnt_q == 16'd0) begin
                cnt_q <= CNT_LOAD;
                if (state_q == SEL_HI) begin
                    hi_q    <= pins_act;
                    state_q <= SEL_LO;
                    sel_q   <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    state_q <= SEL_HI;
                    sel_q   <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_q - 16'd1;
            end
        end
    end

    assign pad.SegaSelect = sel_q;
    assign pad.SegaUpdate = upd_q;
    assign pad.SegaData   = data_q;

endmodule

// File: tb/tb_sega_pad_reader.sv
// Bench for sega_pad_reader: a select-aware pad model drives the pins and a
// button-level reference predicts each published word.
module tb_sega_pad_reader;
    import sega_pkg::*;

    localparam int HP   = 8;
    localparam int SCAN = 2 * HP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  hi_pins_n = 6'h3f;
    logic [5:0]  lo_pins_n = 6'h3f;
    logic [31:0] cur = 32'd0;
    int          checks = 0;
    int          errors = 0;

    sega_pad_reader_if pad_if();

    // The pad answers combinationally to the select line it is given.
    assign pad_if.PadPins_n = (pad_if.SegaSelect === 1'b0) ? lo_pins_n : hi_pins_n;

    sega_pad_reader #(.HALF_PERIOD(HP)) dut (
        .clk (clk),
        .rst (rst),
        .pad (pad_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // btn order: {Start, A, C, B, Right, Left, Down, Up}
    function automatic logic [31:0] model_word(input bit present, input logic [7:0] btn);
        if (!present) return 32'd0;
        return 32'h100 | {24'd0, btn};
    endfunction

    task automatic set_pad(input bit present, input logic [7:0] btn);
        if (present) begin
            hi_pins_n = ~{btn[5], btn[4], btn[3], btn[2], btn[1], btn[0]};
            lo_pins_n = ~{btn[7], btn[6], 1'b1, 1'b1, btn[1], btn[0]};
        end else begin
            hi_pins_n = 6'($urandom);
            lo_pins_n = 6'($urandom);
            if (lo_pins_n[3:2] == 2'b00) lo_pins_n[2] = 1'b1;
        end
    endtask

    // Waits for the next SegaUpdate (bounded), watching SegaData hold its old value,
    // then returns just after the edge that loads the new word.
    task automatic run_scan(input logic [31:0] prev, output logic [31:0] newd,
                            output int ncyc, output bit stable);
        ncyc   = -1;
        stable = 1'b1;
        for (int i = 0; i < 4 * SCAN; i++) begin
            @(negedge clk);
            if (pad_if.SegaUpdate === 1'b1) begin
                ncyc = i + 1;
                break;
            end
            if (pad_if.SegaData !== prev) stable = 1'b0;
        end
        @(posedge clk);
        #1;
        newd = pad_if.SegaData;
    endtask

    task automatic test_reset;
        logic exp_sel;
        logic exp_upd;
        rst = 1'b1;
        hi_pins_n = 6'h3f;
        lo_pins_n = 6'h3f;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pad_if.SegaSelect !== 1'b1) begin
            errors++; $display("FAIL reset_sel: got %b expected 1", pad_if.SegaSelect);
        end
        checks++;
        if (pad_if.SegaData !== 32'd0) begin
            errors++; $display("FAIL reset_data: got %h expected 00000000", pad_if.SegaData);
        end
        checks++;
        if (pad_if.SegaUpdate !== 1'b0) begin
            errors++; $display("FAIL reset_upd: got %b expected 0", pad_if.SegaUpdate);
        end
        rst = 1'b0;
        for (int k = 0; k < SCAN; k++) begin
            @(negedge clk);
            exp_sel = ((k / HP) % 2) == 0;
            exp_upd = (k == SCAN - 1);
            checks++;
            if (pad_if.SegaSelect !== exp_sel) begin
                errors++; $display("FAIL idle_sel cycle %0d: got %b expected %b", k, pad_if.SegaSelect, exp_sel);
            end
            checks++;
            if (pad_if.SegaUpdate !== exp_upd) begin
                errors++; $display("FAIL idle_upd cycle %0d: got %b expected %b", k, pad_if.SegaUpdate, exp_upd);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (pad_if.SegaData !== 32'd0) begin
            errors++; $display("FAIL idle_data: got %h expected 00000000", pad_if.SegaData);
        end
        cur = pad_if.SegaData;
    endtask

    task automatic test_present_idle;
        logic [31:0] d;
        int n;
        bit st;
        set_pad(1'b1, 8'h00);
        run_scan(cur, d, n, st);
        checks++;
        if (n !== SCAN) begin
            errors++; $display("FAIL present_period: got %0d expected %0d", n, SCAN);
        end
        checks++;
        if (d !== 32'h0000_0100) begin
            errors++; $display("FAIL present_idle: got %h expected 00000100", d);
        end
        cur = d;
    endtask

    task automatic test_up_b_start;
        logic [31:0] d;
        int n;
        bit st;
        set_pad(1'b1, 8'b1001_0001);
        run_scan(cur, d, n, st);
        checks++;
        if (d !== 32'h0000_0191) begin
            errors++; $display("FAIL up_b_start: got %h expected 00000191", d);
        end
        cur = d;
    endtask

    task automatic test_all_release;
        logic [31:0] d;
        int n;
        bit st;
        set_pad(1'b1, 8'hff);
        run_scan(cur, d, n, st);
        checks++;
        if (d !== 32'h0000_01ff) begin
            errors++; $display("FAIL all_pressed: got %h expected 000001ff", d);
        end
        cur = d;
        set_pad(1'b1, 8'h00);
        run_scan(cur, d, n, st);
        checks++;
        if (st !== 1'b1) begin
            errors++; $display("FAIL hold_between_updates: got changed expected stable at %h", cur);
        end
        checks++;
        if (n !== SCAN) begin
            errors++; $display("FAIL release_period: got %0d expected %0d", n, SCAN);
        end
        checks++;
        if (d !== 32'h0000_0100) begin
            errors++; $display("FAIL released: got %h expected 00000100", d);
        end
        cur = d;
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        int n;
        bit st;
        hi_pins_n = ~6'b010000;
        lo_pins_n = ~6'b001100;
        run_scan(cur, d, n, st);
        checks++;
        if (d[SEGA_B] !== 1'b1) begin
            errors++; $display("FAIL glitch_b: got %b expected 1", d[SEGA_B]);
        end
        checks++;
        if (d[SEGA_A] !== 1'b0) begin
            errors++; $display("FAIL glitch_a: got %b expected 0", d[SEGA_A]);
        end
        checks++;
        if (d !== 32'h0000_0110) begin
            errors++; $display("FAIL glitch_word: got %h expected 00000110", d);
        end
        cur = d;
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic [31:0] exp;
        int n;
        bit st;
        set_pad(1'b1, 8'h5a);
        exp = model_word(1'b1, 8'h5a);
        run_scan(cur, d, n, st);
        checks++;
        if (d !== exp) begin
            errors++; $display("FAIL pre_reset_word: got %h expected %h", d, exp);
        end
        repeat (HP + 5) @(posedge clk);
        #1;
        checks++;
        if (pad_if.SegaSelect !== 1'b0) begin
            errors++; $display("FAIL mid_sel_lo: got %b expected 0", pad_if.SegaSelect);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (pad_if.SegaSelect !== 1'b1) begin
            errors++; $display("FAIL mid_reset_sel: got %b expected 1", pad_if.SegaSelect);
        end
        checks++;
        if (pad_if.SegaData !== 32'd0) begin
            errors++; $display("FAIL mid_reset_data: got %h expected 00000000", pad_if.SegaData);
        end
        run_scan(32'd0, d, n, st);
        checks++;
        if (n !== SCAN) begin
            errors++; $display("FAIL mid_reset_latency: got %0d expected %0d", n, SCAN);
        end
        checks++;
        if (st !== 1'b1) begin
            errors++; $display("FAIL mid_reset_hold: got changed expected 00000000");
        end
        checks++;
        if (d !== exp) begin
            errors++; $display("FAIL mid_reset_word: got %h expected %h", d, exp);
        end
        cur = d;
    endtask

    task automatic test_random;
        logic [31:0] d;
        logic [31:0] exp;
        logic [7:0]  btn;
        bit present;
        int n;
        bit st;
        for (int it = 0; it < 12; it++) begin
            present = ($urandom_range(0, 3) != 0);
            btn     = 8'($urandom);
            set_pad(present, btn);
            exp = model_word(present, btn);
            run_scan(cur, d, n, st);
            checks++;
            if (n !== SCAN || st !== 1'b1) begin
                errors++; $display("FAIL rand_timing %0d: got period %0d stable %b expected %0d stable 1", it, n, st, SCAN);
            end
            checks++;
            if (d !== exp) begin
                errors++; $display("FAIL rand_word %0d: got %h expected %h (present %b btn %h)", it, d, exp, present, btn);
            end
            cur = d;
        end
    endtask

    initial begin
        test_reset();
        test_present_idle();
        test_up_b_start();
        test_all_release();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
